// File: rtl/prefix_adder_pipe.sv
// Pipelined Sklansky prefix adder/subtractor with valid/ready handshake.
// A single global enable stalls every stage while the output beat is not taken.
module prefix_adder_pipe #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned PIPE_EVERY = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);
    localparam int unsigned LEVELS = $clog2(WIDTH);

    logic w_en;
    assign w_en     = !(out_valid && !out_ready);
    assign in_ready = w_en;

    // Carry-in is folded into bit 0's generate so the tree stays a power of two;
    // the raw propagate still travels for the sum XOR.
    logic [WIDTH-1:0] w_beff;
    logic [WIDTH-1:0] w_p0;
    logic [WIDTH-1:0] w_g0;
    logic             w_c0;
    always_comb begin
        w_beff  = sub ? ~b : b;
        w_c0    = sub ? 1'b1 : cin;
        w_p0    = a ^ w_beff;
        w_g0    = a & w_beff;
        w_g0[0] = w_g0[0] | (w_p0[0] & w_c0);
    end

    logic [WIDTH-1:0] r_g0;
    logic [WIDTH-1:0] r_p0;
    logic             r_c00;
    logic             r_v0;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_v0 <= 1'b0;
        end else if (w_en) begin
            r_v0  <= in_valid;
            r_g0  <= w_g0;
            r_p0  <= w_p0;
            r_c00 <= w_c0;
        end
    end

    logic [LEVELS:0][WIDTH-1:0] w_G;
    logic [LEVELS:0][WIDTH-1:0] w_P;
    logic [LEVELS:0][WIDTH-1:0] w_ps;
    logic [LEVELS:0]            w_c0s;
    logic [LEVELS:0]            w_v;

    assign w_G[0]   = r_g0;
    assign w_P[0]   = r_p0;
    assign w_ps[0]  = r_p0;
    assign w_c0s[0] = r_c00;
    assign w_v[0]   = r_v0;

    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        logic [WIDTH-1:0] w_gn;
        logic [WIDTH-1:0] w_pn;

        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (((i >> (k - 1)) & 1) == 1) begin : g_comb
                localparam int J = ((i >> (k - 1)) << (k - 1)) - 1;
                assign w_gn[i] = w_G[k-1][i] | (w_P[k-1][i] & w_G[k-1][J]);
                assign w_pn[i] = w_P[k-1][i] & w_P[k-1][J];
            end else begin : g_pass
                assign w_gn[i] = w_G[k-1][i];
                assign w_pn[i] = w_P[k-1][i];
            end
        end

        if (((k % PIPE_EVERY) == 0) && (k < LEVELS)) begin : g_reg
            logic [WIDTH-1:0] r_g;
            logic [WIDTH-1:0] r_p;
            logic [WIDTH-1:0] r_ps;
            logic             r_c0;
            logic             r_v;
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_v <= 1'b0;
                end else if (w_en) begin
                    r_v  <= w_v[k-1];
                    r_g  <= w_gn;
                    r_p  <= w_pn;
                    r_ps <= w_ps[k-1];
                    r_c0 <= w_c0s[k-1];
                end
            end
            assign w_G[k]   = r_g;
            assign w_P[k]   = r_p;
            assign w_ps[k]  = r_ps;
            assign w_c0s[k] = r_c0;
            assign w_v[k]   = r_v;
        end else begin : g_wire
            assign w_G[k]   = w_gn;
            assign w_P[k]   = w_pn;
            assign w_ps[k]  = w_ps[k-1];
            assign w_c0s[k] = w_c0s[k-1];
            assign w_v[k]   = w_v[k-1];
        end
    end

    // Group propagate of the last level has no consumer.
    logic [WIDTH-1:0] w_unused_p;
    assign w_unused_p = w_P[LEVELS];

    logic [WIDTH-1:0] w_carry;
    logic [WIDTH-1:0] w_s;
    logic             w_cout;
    logic             w_ovf;
    always_comb begin
        w_carry = {w_G[LEVELS][WIDTH-2:0], w_c0s[LEVELS]};
        w_s     = w_ps[LEVELS] ^ w_carry;
        w_cout  = w_G[LEVELS][WIDTH-1];
        w_ovf   = w_G[LEVELS][WIDTH-2] ^ w_G[LEVELS][WIDTH-1];
    end

    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_ovf;
    logic             r_out_valid;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_s         <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_en) begin
            r_out_valid <= w_v[LEVELS];
            r_s         <= w_s;
            r_cout      <= w_cout;
            r_ovf       <= w_ovf;
        end
    end

    assign out_valid = r_out_valid;
    assign s         = r_s;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Bench for prefix_adder_pipe: three configurations driven in lockstep, each
// checked against an arithmetic reference model through an in-order scoreboard.
module tb_prefix_adder_pipe;
    typedef struct packed {
        logic [63:0] s;
        logic        cout;
        logic        ovf;
        int unsigned cyc;
    } exp_t;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic        sub;
    } beat_t;

    localparam int unsigned NDUT = 3;
    int unsigned W [NDUT] = '{32, 8, 64};
    int unsigned L [NDUT] = '{4, 4, 3};

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic out_ready;
    logic [63:0] ta  [NDUT];
    logic [63:0] tbv [NDUT];
    logic        tcin[NDUT];
    logic        tsub[NDUT];
    logic [NDUT-1:0] ir, ov, oc, oo;
    logic [31:0] s0;
    logic [7:0]  s1;
    logic [63:0] s2;
    logic [63:0] so [NDUT];

    always #5 clk = ~clk;

    assign so[0] = {32'h0, s0};
    assign so[1] = {56'h0, s1};
    assign so[2] = s2;

    prefix_adder_pipe #(.WIDTH(32), .PIPE_EVERY(2)) u_d0 (
        .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(ir[0]),
        .a(ta[0][31:0]), .b(tbv[0][31:0]), .cin(tcin[0]), .sub(tsub[0]),
        .out_valid(ov[0]), .out_ready(out_ready), .s(s0), .cout(oc[0]), .ovf(oo[0]));
    prefix_adder_pipe #(.WIDTH(8), .PIPE_EVERY(1)) u_d1 (
        .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(ir[1]),
        .a(ta[1][7:0]), .b(tbv[1][7:0]), .cin(tcin[1]), .sub(tsub[1]),
        .out_valid(ov[1]), .out_ready(out_ready), .s(s1), .cout(oc[1]), .ovf(oo[1]));
    prefix_adder_pipe #(.WIDTH(64), .PIPE_EVERY(3)) u_d2 (
        .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(ir[2]),
        .a(ta[2]), .b(tbv[2]), .cin(tcin[2]), .sub(tsub[2]),
        .out_valid(ov[2]), .out_ready(out_ready), .s(s2), .cout(oc[2]), .ovf(oo[2]));

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    logic lat_on = 1'b0;
    exp_t q0[$], q1[$], q2[$];
    logic        held [NDUT];
    logic [63:0] hs   [NDUT];
    logic        hc   [NDUT];
    logic        ho   [NDUT];

    task automatic chk(input string tag, input int unsigned d,
                       input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed %0h expected %0h", tag, d, obs, exp);
        end
    endtask

    // Reference: plain modular arithmetic and sign rules at width w.
    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic cin, input logic sub, input int unsigned w);
        exp_t r;
        logic [64:0] mask, full;
        logic [63:0] am, bm;
        logic sa, sb, sr;
        mask = (65'd1 << w) - 65'd1;
        am   = a & mask[63:0];
        bm   = b & mask[63:0];
        if (sub) full = {1'b0, am} - {1'b0, bm};
        else     full = {1'b0, am} + {1'b0, bm} + {64'd0, cin};
        r.s    = full[63:0] & mask[63:0];
        r.cout = sub ? (am >= bm) : full[w];
        sa = am[w-1];
        sb = bm[w-1];
        sr = r.s[w-1];
        r.ovf = sub ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
        r.cyc = 0;
        return r;
    endfunction

    function automatic int unsigned qsize(input int unsigned d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic qpush(input int unsigned d, input exp_t e);
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic exp_t qpop(input int unsigned d);
        case (d)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    task automatic set_beat(input beat_t bt);
        for (int d = 0; d < NDUT; d++) begin
            ta[d]   = bt.a;
            tbv[d]  = bt.b;
            tcin[d] = bt.cin;
            tsub[d] = bt.sub;
        end
    endtask

    task automatic set_random();
        for (int d = 0; d < NDUT; d++) begin
            ta[d]   = {$urandom, $urandom};
            tbv[d]  = {$urandom, $urandom};
            tcin[d] = 1'($urandom_range(1, 0));
            tsub[d] = 1'($urandom_range(1, 0));
        end
    endtask

    // One cycle: inputs already driven after the falling edge; evaluate the
    // handshakes just before the rising edge, then advance to the next falling edge.
    task automatic tick();
        exp_t e;
        #1;
        for (int unsigned d = 0; d < NDUT; d++) begin
            if (!rst) begin
                if (held[d]) begin
                    chk("stall_valid", d, {63'd0, ov[d]}, 64'd1);
                    chk("stall_s",     d, so[d], hs[d]);
                    chk("stall_cout",  d, {63'd0, oc[d]}, {63'd0, hc[d]});
                    chk("stall_ovf",   d, {63'd0, oo[d]}, {63'd0, ho[d]});
                end
                chk("in_ready", d, {63'd0, ir[d]}, {63'd0, !(ov[d] && !out_ready)});
                if (ov[d] && out_ready) begin
                    if (qsize(d) == 0) begin
                        chk("spurious_out", d, {63'd0, ov[d]}, 64'd0);
                    end else begin
                        e = qpop(d);
                        chk("sum",  d, so[d], e.s);
                        chk("cout", d, {63'd0, oc[d]}, {63'd0, e.cout});
                        chk("ovf",  d, {63'd0, oo[d]}, {63'd0, e.ovf});
                        if (lat_on) chk("latency", d, 64'(cyc - e.cyc), 64'(L[d]));
                    end
                end
                if (in_valid && ir[d]) begin
                    e = model(ta[d], tbv[d], tcin[d], tsub[d], W[d]);
                    e.cyc = cyc;
                    qpush(d, e);
                end
                held[d] = ov[d] && !out_ready;
                hs[d] = so[d];
                hc[d] = oc[d];
                ho[d] = oo[d];
            end
        end
        @(posedge clk);
        if (rst) begin
            q0.delete();
            q1.delete();
            q2.delete();
            for (int d = 0; d < NDUT; d++) held[d] = 1'b0;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic check_empty(input string tag);
        for (int unsigned d = 0; d < NDUT; d++) chk(tag, d, 64'(qsize(d)), 64'd0);
    endtask

    beat_t directed [7] = '{
        '{64'hFFFF_FFFF, 64'h1, 1'b0, 1'b0},
        '{64'h5,         64'h7, 1'b0, 1'b1},
        '{64'h7,         64'h5, 1'b0, 1'b1},
        '{64'h8000_0000, 64'h1, 1'b0, 1'b1},
        '{64'h7FFF_FFFF, 64'h1, 1'b0, 1'b0},
        '{64'h0,         64'h0, 1'b1, 1'b0},
        '{64'h7,         64'h5, 1'b1, 1'b1}
    };

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int d = 0; d < NDUT; d++) held[d] = 1'b0;
        set_beat(directed[0]);
        repeat (3) tick();
        rst = 1'b0;
        #1;
        for (int unsigned d = 0; d < NDUT; d++) begin
            chk("rst_out_valid", d, {63'd0, ov[d]}, 64'd0);
            chk("rst_s",         d, so[d], 64'd0);
            chk("rst_cout",      d, {63'd0, oc[d]}, 64'd0);
            chk("rst_ovf",       d, {63'd0, oo[d]}, 64'd0);
            chk("rst_in_ready",  d, {63'd0, ir[d]}, 64'd1);
        end

        // Directed corner cases, latency tracked per beat.
        lat_on = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            set_beat(directed[i]);
            tick();
        end
        in_valid = 1'b0;
        repeat (6) tick();
        check_empty("directed_drain");

        // Back-to-back random beats at full throughput.
        for (int i = 0; i < 1000; i++) begin
            in_valid = 1'b1;
            set_random();
            tick();
        end
        in_valid = 1'b0;
        repeat (6) tick();
        check_empty("b2b_drain");

        // Random valid and backpressure.
        lat_on = 1'b0;
        for (int i = 0; i < 600; i++) begin
            in_valid  = 1'($urandom_range(3, 0) != 0);
            out_ready = 1'($urandom_range(2, 0) != 0);
            set_random();
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (8) tick();
        check_empty("toggle_drain");

        // Fill, then hold the consumer off for five cycles.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            set_random();
            tick();
        end
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_random();
            #1;
            for (int unsigned d = 0; d < NDUT; d++) chk("full_stall_in_ready", d, {63'd0, ir[d]}, 64'd0);
            tick();
        end
        out_ready = 1'b1;
        in_valid = 1'b0;
        repeat (8) tick();
        check_empty("stall_drain");

        // Reset with beats in flight: nothing may emerge afterwards.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            set_random();
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        for (int unsigned d = 0; d < NDUT; d++) chk("reset_flush", d, {63'd0, ov[d]}, 64'd0);
        repeat (8) tick();
        lat_on = 1'b1;
        in_valid = 1'b1;
        set_beat(directed[3]);
        tick();
        in_valid = 1'b0;
        repeat (6) tick();
        check_empty("post_reset_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/prefix_adder_pipe.md
# prefix_adder_pipe

Parametrised, pipelined Sklansky prefix adder/subtractor with a valid/ready stream interface. It generalises the fixed-width combinational prefix adder to any power-of-two width and adds configurable pipeline depth, subtract mode, a signed-overflow flag and full backpressure. It sits as the integer add/sub execution unit between an operand issue stage and a result writeback stage.

## Interface
- WIDTH, 32, operand width; power of two, 4..64.
- PIPE_EVERY, 2, pipeline register inserted after every PIPE_EVERY prefix levels; 1..log2(WIDTH).
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add mode only).
- sub  in  1  0: a+b+cin; 1: a-b (cin ignored).
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts result this cycle.
- s  out  WIDTH  sum/difference.
- cout  out  1  carry out of MSB (sub mode: 1 = no borrow).
- ovf  out  1  two's-complement signed overflow.

## Operation
- Accept when in_valid && in_ready; deliver when out_valid && out_ready.
- Operand conditioning: b_eff = sub ? ~b : b; c0 = sub ? 1 : cin.
- Bit level: g_i = a_i & b_eff_i, p_i = a_i ^ b_eff_i; c0 enters as generate of bit -1 (propagate 0).
- Prefix tree: Sklansky, LEVELS = log2(WIDTH) levels; level k combines each group with the group-generate of the preceding 2^(k-1)-bit block via G = Gh | (Ph & Gl), P = Ph & Pl.
- Sum: s_i = p_i ^ G[i-1:-1]; cout = G[WIDTH-1:-1]; ovf = carry into MSB ^ cout.
- Pipeline: stage 0 registers conditioned operands (p, g, c0, valid); register after level k when k mod PIPE_EVERY == 0 and k < LEVELS; final stage registers s, cout, ovf, out_valid. Each stage carries a valid bit; p_i for sum bits travels with the stage.
- Stall: global enable en = !(out_valid && !out_ready). When en=0 every stage register (data and valid) holds. in_ready = en.
- Bubbles propagate as valid=0; output registers may hold stale data when out_valid=0.
- Reset: all valid bits 0, s=0, cout=0, ovf=0, out_valid=0; in_ready=1 in the cycle after reset deasserts. Reset mid-operation discards all in-flight beats; no partial results emerge.

## Timing
- Latency L = 2 + floor((LEVELS-1)/PIPE_EVERY) cycles from accept edge to out_valid (WIDTH=32, PIPE_EVERY=2: L=4; WIDTH=8, PIPE_EVERY=1: L=4; WIDTH=16, PIPE_EVERY=4: L=2).
- Throughput: one beat per cycle with out_ready held high.
- in_ready is combinational from out_valid/out_ready only (no path from in_valid).
- out_valid, s, cout, ovf driven directly from registers.
- Simultaneous accept and deliver in one cycle is normal flow; no beat lost or duplicated.
- out_valid && !out_ready: s/cout/ovf stable until delivered; in_ready=0 in same cycle.
- Combinational depth between registers ≤ PIPE_EVERY prefix levels (+ conditioning or sum XOR at ends).

## Test plan
- WIDTH=32: a=0xFFFFFFFF, b=1, cin=0, sub=0 -> 4 cycles later s=0x00000000, cout=1, ovf=0.
- sub=1, a=5, b=7 -> s=0xFFFFFFFE, cout=0, ovf=0; a=7, b=5 -> s=2, cout=1; a=0x80000000, b=1 -> s=0x7FFFFFFF, ovf=1.
- a=0x7FFFFFFF, b=1, cin=0 -> s=0x80000000, ovf=1, cout=0; cin=1 with a=b=0 -> s=1.
- 1000 random back-to-back beats, out_ready=1 -> one result per cycle, in order, matching reference model; then random out_ready toggling -> no loss/duplication, outputs stable while stalled.
- Full pipe, out_ready=0 for 5 cycles -> in_ready=0 throughout, s unchanged; release -> beats drain in order.
- Reset asserted with 3 beats in flight -> next cycle out_valid=0, no stale result ever appears; repeat sweep for WIDTH=8/PIPE_EVERY=1 and WIDTH=64/PIPE_EVERY=3 checking L.
